sram_mem_controller: RTL and testbench

// Sequences MEM-stage data accesses (MEM_R_EN/MEM_W_EN from the decode controls)

---
 rtl/arm_pkg.sv | 18 +
 rtl/sram_mem_controller.sv | 105 ++++++++++
 tb/tb_sram_mem_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM datapath: memory-controller state encoding and data memory base.
package arm_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int DATA_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_LOW  = S_LOW,
    ST_HIGH = S_HIGH,
    ST_DONE = S_DONE
  } mem_state_t;

endpackage

// File: rtl/sram_mem_controller.sv
// MEM-stage controller that splits each 32-bit load/store into two 16-bit asynchronous SRAM phases
// and holds the pipeline (ready=0) until the word transfer finishes.
import arm_pkg::*;

module sram_mem_controller #(
  parameter int BASE_ADDR    = DATA_BASE_ADDR,
  parameter int PHASE_CYCLES = 2,
  parameter int SRAM_AW      = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  mem_state_t           state;
  logic [CW-1:0]        cnt;
  logic                 is_wr;
  logic [SRAM_AW-2:0]   word;
  logic [15:0]          wdata_hi;

  // Byte address to SRAM word index; out-of-range addresses simply wrap.
  function automatic logic [SRAM_AW-2:0] word_of(input logic [31:0] a);
    return (SRAM_AW-1)'((a - 32'(BASE_ADDR)) >> 2);
  endfunction

  assign ready = (state == ST_DONE) | ((state == ST_IDLE) & ~rd_en & ~wr_en);

  // Pin registers are loaded with the values for the state being entered, so every
  // SRAM pin is a flop and never sees the pipeline inputs combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_wr      <= 1'b0;
      word       <= '0;
      wdata_hi   <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rd_en | wr_en) begin
            state      <= ST_LOW;
            cnt        <= '0;
            is_wr      <= wr_en;
            word       <= word_of(address);
            wdata_hi   <= write_data[31:16];
            sram_addr  <= {word_of(address), 1'b0};
            sram_dq_o  <= write_data[15:0];
            sram_dq_oe <= wr_en;
            sram_oe_n  <= wr_en;
            sram_we_n  <= 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt == LAST) begin
            state     <= ST_HIGH;
            cnt       <= '0;
            sram_addr <= {word, 1'b1};
            sram_dq_o <= wdata_hi;
            sram_we_n <= 1'b1;
            if (!is_wr) read_data[15:0] <= sram_dq_i;
          end else begin
            cnt       <= cnt + CW'(1);
            sram_we_n <= ~is_wr;
          end
        end
        ST_HIGH: begin
          if (cnt == LAST) begin
            state      <= ST_DONE;
            cnt        <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!is_wr) read_data[31:16] <= sram_dq_i;
          end else begin
            cnt       <= cnt + CW'(1);
            sram_we_n <= ~is_wr;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: behavioural SRAM plus a word-level reference memory,
// directed cases followed by randomized loads and stores.
module tb_sram_mem_controller;

  localparam int P = 2;
  localparam int XLAT = 2 * P + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;
  logic        sram_we_n;
  logic        sram_oe_n;

  sram_mem_controller #(.BASE_ADDR(1024), .PHASE_CYCLES(P), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Initial half-word contents shared by the SRAM model and the reference memory.
  function automatic logic [15:0] init_half(input int i);
    if (i == 0) return 16'h5678;
    if (i == 1) return 16'h1234;
    if (i < 256) return 16'(i * 40503 + 4369);
    return 16'h0000;
  endfunction

  logic [15:0] sram [0:262143];
  assign sram_dq_i = sram_oe_n ? 16'h0000 : sram[sram_addr];

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = init_half(i);
    forever begin
      @(posedge clk);
      if (!sram_we_n && sram_dq_oe) sram[sram_addr] = sram_dq_o;
    end
  end

  logic [31:0] ref_mem [0:131071];
  logic [31:0] ref_rd = '0;
  int total = 0;
  int passed = 0;
  int failed = 0;

  function automatic int word_idx(input logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the controller idle; returns once the
  // transfer has been acknowledged and the controller is back in idle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int drop_at,
                        output int lat, output int rdy_cyc,
                        output int we_lo, output int dq_hi, output int oe_lo);
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    lat = -1; rdy_cyc = -1; we_lo = 0; dq_hi = 0; oe_lo = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == drop_at) begin rd_en = 1'b0; wr_en = 1'b0; end
      @(negedge clk);
      if (!sram_we_n) we_lo++;
      if (sram_dq_oe) dq_hi++;
      if (!sram_oe_n) oe_lo++;
      if (ready) begin lat = c; rdy_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    if (lat < 0) check("ready_timeout", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic xact(input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] data,
                      input int drop_at, output int rdy_cyc);
    int lat, we_lo, dq_hi, oe_lo, w;
    access(rd, wr, addr, data, drop_at, lat, rdy_cyc, we_lo, dq_hi, oe_lo);
    w = word_idx(addr);
    check($sformatf("%s_latency", tag), lat, XLAT);
    if (wr) begin
      ref_mem[w] = data;
      if (drop_at < 0) begin
        check($sformatf("%s_we_low_cycles", tag), we_lo, 2 * (P - 1));
        check($sformatf("%s_dq_oe_cycles", tag), dq_hi, 2 * P);
        check($sformatf("%s_oe_n_low_cycles", tag), oe_lo, 0);
      end
      check($sformatf("%s_sram_lo", tag), {16'h0, sram[2 * w]}, {16'h0, data[15:0]});
      check($sformatf("%s_sram_hi", tag), {16'h0, sram[2 * w + 1]}, {16'h0, data[31:16]});
    end else begin
      ref_rd = ref_mem[w];
      if (drop_at < 0) begin
        check($sformatf("%s_oe_n_low_cycles", tag), oe_lo, 2 * P);
        check($sformatf("%s_we_low_cycles", tag), we_lo, 0);
        check($sformatf("%s_dq_oe_cycles", tag), dq_hi, 0);
      end
    end
    check($sformatf("%s_read_data", tag), read_data, ref_rd);
  endtask

  initial begin
    int s, r, gap, kind;
    logic rd, wr;
    logic [31:0] addr, data;

    for (int w = 0; w < 131072; w++) ref_mem[w] = {init_half(2 * w + 1), init_half(2 * w)};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_data", read_data, 32'h0);
    check("rst_sram_addr", {14'h0, sram_addr}, 32'h0);
    check("rst_dq_o", {16'h0, sram_dq_o}, 32'h0);
    check("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    check("rst_we_n", {31'h0, sram_we_n}, 32'h1);
    check("rst_oe_n", {31'h0, sram_oe_n}, 32'h1);
    check("rst_ready", {31'h0, ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed: load, store, back-to-back, flush, rd+wr together
    xact("load1024", 1'b1, 1'b0, 32'd1024, 32'h0, -1, r);
    check("load1024_value", read_data, 32'h12345678);

    xact("store1032", 1'b0, 1'b1, 32'd1032, 32'hCAFEBABE, -1, r);
    check("store1032_half4", {16'h0, sram[4]}, 32'h0000BABE);
    check("store1032_half5", {16'h0, sram[5]}, 32'h0000CAFE);

    s = cyc;
    xact("b2b_store", 1'b0, 1'b1, 32'd1028, 32'hA5A50F0F, -1, r);
    xact("b2b_load", 1'b1, 1'b0, 32'd1028, 32'h0, -1, r);
    check("b2b_value", read_data, 32'hA5A50F0F);
    check("b2b_total_cycles", r - s, 2 * XLAT + 1);

    xact("flush_load", 1'b1, 1'b0, 32'd1032, 32'h0, 2, r);
    check("flush_value", read_data, 32'hCAFEBABE);

    xact("rdwr_both", 1'b1, 1'b1, 32'd1024, 32'h0000FFFF, -1, r);
    check("rdwr_half0", {16'h0, sram[0]}, 32'h0000FFFF);
    check("rdwr_half1", {16'h0, sram[1]}, 32'h00000000);
    check("rdwr_read_data_kept", read_data, 32'hCAFEBABE);

    // Randomized loads and stores, including addresses below the base that wrap
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      rd = (kind == 0 || kind == 1 || kind == 3);
      wr = (kind == 2 || kind == 3);
      addr = 32'd1024 + 32'(4 * $urandom_range(0, 63));
      if (i % 10 == 9) addr = 32'd1024 - 32'(4 * $urandom_range(1, 4));
      data = $urandom;
      xact($sformatf("rand%0d", i), rd, wr, addr, data, -1, r);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check($sformatf("rand%0d_idle_ready", i), {31'h0, ready}, 32'h1);
        @(posedge clk); #1;
      end
    end

    // Reset in the middle of a store's low phase
    wr_en = 1'b1; address = 32'd1024 + 32'd800; write_data = 32'h13579BDF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_we_active", {31'h0, sram_we_n}, 32'h0);
    rst = 1'b1; wr_en = 1'b0;
    @(posedge clk); #1;
    check("midrst_we_n", {31'h0, sram_we_n}, 32'h1);
    check("midrst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    check("midrst_read_data", read_data, 32'h0);
    check("midrst_ready", {31'h0, ready}, 32'h1);
    rst = 1'b0;
    ref_rd = 32'h0;
    @(posedge clk); #1;
    xact("post_rst_load", 1'b1, 1'b0, 32'd1024, 32'h0, -1, r);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
